alu_arbiter: RTL and testbench

- Shares one combinational 4-bit ALU between two requesters.
- Each requester issues a command (op, A, B) over a valid/ready handshake and receives its result (R, flag) on a dedicated response handshake.
- Round-robin arbitration; one operation in flight at a time.
- Sits between the ALU instance and the two client blocks (e.g., two sequencers or a CPU port plus a test port).

---
 rtl/alu_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Purpose: shares one external combinational ALU between two requesters, round-robin, one op in flight.
// Latency: the result is valid two cycles after the accept cycle; commands are spaced at least three cycles apart.
// Backpressure: req*_ready stays low while busy; an untaken response holds RESP until its owner's rsp_ready.
//
// Ports:
//   clk, rst_n                      rising-edge clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b         command handshake per requester (N = 0, 1)
//   rspN_valid/ready/r/flag         response handshake per requester
//   alu_a/alu_b/alu_sel             operands and select code to the external ALU
//   alu_r/alu_flag                  result and flag (A > B, unsigned) from the external ALU
//   busy                            high whenever the FSM is not IDLE
//   last_grant                      index of the most recently accepted requester
module alu_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0 command
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  // requester 1 command
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  // requester 0 response
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_r,
  output logic             rsp0_flag,
  // requester 1 response
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_r,
  output logic             rsp1_flag,
  // shared ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_flag,
  // status
  output logic             busy,
  output logic             last_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             winner;        // requester that would be granted this cycle
  logic             any_valid;
  logic             accept;        // command handshake with the winner
  logic             rsp_hs;        // response handshake with the owner
  logic             owner;         // requester whose operation is in flight
  logic             last_grant_q;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // Each requester keeps its own result so its r/flag stay at its last
  // result even after the other requester has been served.
  logic [WIDTH-1:0] r0_q;
  logic [WIDTH-1:0] r1_q;
  logic             flag0_q;
  logic             flag1_q;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // On a tie the requester that did not win last time goes first; because
  // last_grant resets to 1, requester 0 wins a tie right after reset.
  always_comb begin
    winner = ~last_grant_q;
    if (req0_valid && !req1_valid) begin
      winner = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      winner = 1'b1;
    end
  end

  assign any_valid = req0_valid | req1_valid;

  // rst_n gates the handshake so a requester holding valid through reset
  // never sees ready while the block is held in reset.
  assign accept = rst_n && (state == IDLE) && any_valid;
  assign rsp_hs = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (state != IDLE);
    if (accept) begin
      req0_ready = ~winner;
      req1_ready = winner;
    end
    if (state == RESP) begin
      rsp0_valid = ~owner;
      rsp1_valid = owner;
    end
  end

  // ---------------------------------------------------------------------------
  // Command capture and grant history
  // ---------------------------------------------------------------------------
  // Operands are only loaded on accept, so they stay stable from EXEC
  // through RESP and the ALU inputs cannot glitch while a result is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= 3'b000;
      a_q          <= '0;
      b_q          <= '0;
      owner        <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      owner        <= winner;
      last_grant_q <= winner;
      if (winner) begin
        op_q <= req1_op;
        a_q  <= req1_a;
        b_q  <= req1_b;
      end else begin
        op_q <= req0_op;
        a_q  <= req0_a;
        b_q  <= req0_b;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result capture
  // ---------------------------------------------------------------------------
  // The ALU is purely combinational, so its output for the latched operands
  // is already settled at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_q    <= '0;
      r1_q    <= '0;
      flag0_q <= 1'b0;
      flag1_q <= 1'b0;
    end else if (state == EXEC) begin
      if (owner) begin
        r1_q    <= alu_r;
        flag1_q <= alu_flag;
      end else begin
        r0_q    <= alu_r;
        flag0_q <= alu_flag;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output wiring
  // ---------------------------------------------------------------------------
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sel    = op_q;
  assign rsp0_r     = r0_q;
  assign rsp0_flag  = flag0_q;
  assign rsp1_r     = r1_q;
  assign rsp1_flag  = flag1_q;
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural stand-in for the external ALU, directed
// steps in one initial block, and a per-requester scoreboard of expected
// {flag, r} pushed when a command is driven and popped when its response appears.
module tb_alu_arbiter;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]       req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             rsp0_valid, rsp0_ready, rsp0_flag;
  logic             rsp1_valid, rsp1_ready, rsp1_flag;
  logic [WIDTH-1:0] rsp0_r, rsp1_r;
  logic [WIDTH-1:0] alu_a, alu_b, alu_r;
  logic [2:0]       alu_sel;
  logic             alu_flag;
  logic             busy, last_grant;

  int tests = 0;
  int fails = 0;

  logic [WIDTH:0] sb0[$];
  logic [WIDTH:0] sb1[$];

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_r(rsp0_r), .rsp0_flag(rsp0_flag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_r(rsp1_r), .rsp1_flag(rsp1_flag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_r(alu_r), .alu_flag(alu_flag),
    .busy(busy), .last_grant(last_grant)
  );

  // External ALU stand-in: 000 add, 001 sub, 010 and, 011 or, 100 xor,
  // 101 eq, 110 shl1, 111 shr1; flag = A > B unsigned.
  function automatic logic [WIDTH:0] alu_model(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = (a == b) ? WIDTH'(1) : '0;
      3'b110:  r = a << 1;
      default: r = a >> 1;
    endcase
    return {a > b, r};
  endfunction

  assign {alu_flag, alu_r} = alu_model(alu_sel, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a sampling point where requester n's response should be valid.
  task automatic check_rsp(input int n, input string tag);
    logic [WIDTH:0] e;
    logic [WIDTH:0] got;
    int             sz;
    sz  = (n != 0) ? sb1.size() : sb0.size();
    got = (n != 0) ? {rsp1_flag, rsp1_r} : {rsp0_flag, rsp0_r};
    check({tag, "_vld"}, (n != 0) ? rsp1_valid : rsp0_valid, 1);
    check({tag, "_sb_entry"}, (sz != 0), 1);
    if (sz != 0) begin
      if (n != 0) e = sb1.pop_front();
      else        e = sb0.pop_front();
      check({tag, "_r"}, got[WIDTH-1:0], e[WIDTH-1:0]);
      check({tag, "_flag"}, got[WIDTH], e[WIDTH]);
    end
  endtask

  // One isolated command with exact cycle timing: ready in the drive cycle,
  // EXEC next, response valid two cycles after the drive cycle.
  task automatic single_op(input int n, input logic [2:0] op,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] er, input logic ef, input string tag);
    @(negedge clk);
    if (n == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      sb0.push_back({ef, er});
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      sb1.push_back({ef, er});
    end
    #1;
    check({tag, "_rdy"}, (n != 0) ? req1_ready : req0_ready, 1);
    check({tag, "_other_rdy"}, (n != 0) ? req0_ready : req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check({tag, "_busy_exec"}, busy, 1);
    check({tag, "_no_early_rsp"}, rsp0_valid | rsp1_valid, 0);
    check({tag, "_alu_in"}, {alu_sel, alu_a, alu_b}, {op, a, b});
    @(negedge clk);
    check({tag, "_busy_resp"}, busy, 1);
    check({tag, "_other_rsp"}, (n != 0) ? rsp0_valid : rsp1_valid, 0);
    check_rsp(n, tag);
    if (n == 0) rsp0_ready = 1'b1;
    else        rsp1_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    check({tag, "_idle"}, busy, 0);
    check({tag, "_rsp_clr"}, rsp0_valid | rsp1_valid, 0);
    check({tag, "_r_hold"}, (n != 0) ? rsp1_r : rsp0_r, er);
    check({tag, "_last_grant"}, last_grant, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int       ng;
    logic [3:0] gseq;

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = 3'b000; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 3'b000; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // ---- Reset state; ready must stay low even with valids held high ----
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst_req0_rdy", req0_ready, 0);
    check("rst_req1_rdy", req1_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_last_grant", last_grant, 1);
    check("rst_rsp_vld", {rsp0_valid, rsp1_valid}, 0);
    check("rst_alu", {alu_sel, alu_a, alu_b}, 0);
    check("rst_rsp_data", {rsp0_flag, rsp0_r, rsp1_flag, rsp1_r}, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // ---- Single requests, wrap and flag ----
    single_op(0, 3'b000, 4'd3, 4'd5, 4'd8, 1'b0, "add");
    single_op(1, 3'b001, 4'd2, 4'd5, 4'hD, 1'b0, "sub_wrap");
    single_op(0, 3'b111, 4'd9, 4'd4, 4'd4, 1'b1, "shr_flag");
    single_op(1, 3'b110, 4'hB, 4'd1, 4'h6, 1'b1, "shl_wrap");

    // ---- Round-robin: both valid right after reset, held continuously ----
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b100; req0_a = 4'hA; req0_b = 4'd6;
    req1_valid = 1'b1; req1_op = 3'b011; req1_a = 4'd1; req1_b = 4'd2;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    ng = 0; gseq = 4'b0000;
    #1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (ng >= 4) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
      end
      if (ng >= 4 && sb0.size() == 0 && sb1.size() == 0) break;
      check("rr_one_rdy", req0_ready & req1_ready, 0);
      if (rsp0_valid) check_rsp(0, "rr_rsp0");
      if (rsp1_valid) check_rsp(1, "rr_rsp1");
      if (req0_ready && ng < 4) begin
        gseq[ng] = 1'b0; ng++;
        sb0.push_back({1'b1, 4'hC});
      end else if (req1_ready && ng < 4) begin
        gseq[ng] = 1'b1; ng++;
        sb1.push_back({1'b0, 4'h3});
      end
      @(negedge clk);
      #1;
    end
    check("rr_grant_count", ng, 4);
    check("rr_grant_seq", gseq, 4'b1010);
    check("rr_drained", sb0.size() + sb1.size(), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // ---- Backpressure on rsp0 with req1 waiting and non-owner ready high ----
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 4'hC; req0_b = 4'hA;
    sb0.push_back({1'b1, 4'h8});
    #1;
    check("bp_rdy0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 3'b101; req1_a = 4'd5; req1_b = 4'd5;
    rsp1_ready = 1'b1;
    @(negedge clk);
    check_rsp(0, "bp_rsp0");
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold_vld", rsp0_valid, 1);
      check("bp_hold_data", {rsp0_flag, rsp0_r}, {1'b1, 4'h8});
      check("bp_req1_blocked", req1_ready, 0);
      check("bp_nonowner_vld", rsp1_valid, 0);
      check("bp_busy", busy, 1);
      @(negedge clk);
    end
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    check("bp_rsp0_clr", rsp0_valid, 0);
    check("bp_req1_rdy", req1_ready, 1);
    sb1.push_back({1'b0, 4'h1});
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    check_rsp(1, "bp_rsp1");
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;

    // ---- Reset while RESP is presenting a result ----
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 4'd7; req0_b = 4'd3;
    #1;
    check("rrst_rdy0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 3'b000; req1_a = 4'd1; req1_b = 4'd1;
    @(negedge clk);
    #1;
    check("rrst_in_resp", rsp0_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rrst_rsp0_vld", rsp0_valid, 0);
    check("rrst_busy", busy, 0);
    check("rrst_alu", {alu_sel, alu_a, alu_b}, 0);
    check("rrst_rsp0_data", {rsp0_flag, rsp0_r}, 0);
    check("rrst_req1_rdy", req1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'd1; req0_b = 4'd2;
    #1;
    check("rrst_last_grant", last_grant, 1);
    check("rrst_idle", busy, 0);
    check("rrst_tie_req0", req0_ready, 1);
    check("rrst_tie_req1", req1_ready, 0);
    sb0.push_back({1'b0, 4'd3});
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check("rrst_no_stale_rsp", rsp0_valid | rsp1_valid, 0);
    @(negedge clk);
    check_rsp(0, "rrst_rsp0");
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    check("rrst_req1_rdy_after", req1_ready, 1);
    sb1.push_back({1'b0, 4'd2});
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    check_rsp(1, "rrst_rsp1");
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;

    check("final_sb_empty", sb0.size() + sb1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
